// File: rtl/mem_bus_pkg.sv
// Shared definitions for the L1 <-> SDRAM controller arbitration path:
// default bus widths, arbiter state encoding and port index constants.
package mem_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic PORT_L1I = 1'b0;
    localparam logic PORT_L1D = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant pick between the two eligible requesters.
// Build option: ARB_ROUND_ROBIN_EN
//   defined   -> on a tie the port that was not served last wins
//   undefined -> fixed priority, the L1D port wins every tie
// A lone eligible request is always picked.
module arb_pick
    import mem_bus_pkg::*;
(
    input  logic elig0_i,
    input  logic elig1_i,
    input  logic rr_last_i,
    output logic valid_o,
    output logic idx_o
);

`ifndef ARB_ROUND_ROBIN_EN
    // last-served history only matters for round robin
    logic unused_rr_last;
    assign unused_rr_last = rr_last_i;
`endif

    // choose the winning port index from the eligible set
    always_comb begin
        valid_o = elig0_i | elig1_i;
        idx_o   = PORT_L1I;
        if (elig0_i && elig1_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            idx_o = ~rr_last_i;
`else
            idx_o = PORT_L1D;
`endif
        end else if (elig1_i) begin
            idx_o = PORT_L1D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter: L1I (port 0) and L1D (port 1) share one SDRAM
// controller start/done bus. One transaction at a time; the granted
// port's addr/data/we are frozen into sdc_* for the whole transaction.
// Build option: ARB_ROUND_ROBIN_EN (tie policy, see arb_pick).
//
// Handshake: a requester raises pN_start and holds it until its pN_done
// pulse; sdc_start is held from the cycle after grant up to and including
// the sdc_done cycle. A requester that drops start early has its done and
// data swallowed, and must show start low for a cycle before it can be
// granted again after a completed transaction.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_data,
    input  logic              p0_we,
    input  logic              p0_start,
    output logic [DATA_W-1:0] p0_q,
    output logic              p0_done,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    input  logic              p1_we,
    input  logic              p1_start,
    output logic [DATA_W-1:0] p1_q,
    output logic              p1_done,
    output logic [ADDR_W-1:0] sdc_addr,
    output logic [DATA_W-1:0] sdc_data,
    output logic              sdc_we,
    output logic              sdc_start,
    input  logic [DATA_W-1:0] sdc_q,
    input  logic              sdc_done,
    output logic              dbg_state
);

    arb_state_e        state_q;
    logic              gnt_q;
    logic              rr_last_q;
    logic              arm0_q, arm1_q;
    logic              arm0_d, arm1_d;
    logic [ADDR_W-1:0] sdc_addr_q;
    logic [DATA_W-1:0] sdc_data_q;
    logic              sdc_we_q;
    logic              sdc_start_q;
    logic [DATA_W-1:0] qhold0_q, qhold1_q;

    logic pick_valid;
    logic pick_idx;
    logic done_now;

    arb_pick u_pick (
        .elig0_i   (p0_start & arm0_q),
        .elig1_i   (p1_start & arm1_q),
        .rr_last_i (rr_last_q),
        .valid_o   (pick_valid),
        .idx_o     (pick_idx)
    );

    assign done_now = (state_q == ARB_BUSY) && sdc_done;

    // route completion only to a granted port that is still asking
    assign p0_done = done_now && (gnt_q == PORT_L1I) && p0_start;
    assign p1_done = done_now && (gnt_q == PORT_L1D) && p1_start;
    assign p0_q    = p0_done ? sdc_q : qhold0_q;
    assign p1_q    = p1_done ? sdc_q : qhold1_q;

    assign sdc_addr  = sdc_addr_q;
    assign sdc_data  = sdc_data_q;
    assign sdc_we    = sdc_we_q;
    assign sdc_start = sdc_start_q;
    assign dbg_state = state_q;

    // disarm on completion; any low-start cycle re-arms (and wins)
    always_comb begin
        arm0_d = arm0_q;
        arm1_d = arm1_q;
        if (done_now && (gnt_q == PORT_L1I)) arm0_d = 1'b0;
        if (done_now && (gnt_q == PORT_L1D)) arm1_d = 1'b0;
        if (!p0_start) arm0_d = 1'b1;
        if (!p1_start) arm1_d = 1'b1;
    end

    // arbitration FSM with registered controller-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= PORT_L1I;
            rr_last_q   <= 1'b1;
            arm0_q      <= 1'b1;
            arm1_q      <= 1'b1;
            sdc_addr_q  <= '0;
            sdc_data_q  <= '0;
            sdc_we_q    <= 1'b0;
            sdc_start_q <= 1'b0;
            qhold0_q    <= '0;
            qhold1_q    <= '0;
        end else begin
            arm0_q <= arm0_d;
            arm1_q <= arm1_d;
            if (p0_done) qhold0_q <= sdc_q;
            if (p1_done) qhold1_q <= sdc_q;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        gnt_q       <= pick_idx;
                        sdc_addr_q  <= pick_idx ? p1_addr : p0_addr;
                        sdc_data_q  <= pick_idx ? p1_data : p0_data;
                        sdc_we_q    <= pick_idx ? p1_we   : p0_we;
                        sdc_start_q <= 1'b1;
                        state_q     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (sdc_done) begin
                        sdc_start_q <= 1'b0;
                        rr_last_q   <= gnt_q;
                        state_q     <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized phase, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

`ifdef ARB_ROUND_ROBIN_EN
    localparam int TIE_FIRST = 0;
`else
    localparam int TIE_FIRST = 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_data [2];
    logic          p_we   [2];
    logic          p_start[2];
    logic [DW-1:0] p0_q, p1_q;
    logic          p0_done, p1_done;
    logic [AW-1:0] sdc_addr;
    logic [DW-1:0] sdc_data;
    logic          sdc_we, sdc_start;
    logic [DW-1:0] sdc_q;
    logic          sdc_done;
    logic          dbg_state;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .p0_addr(p_addr[0]), .p0_data(p_data[0]), .p0_we(p_we[0]), .p0_start(p_start[0]),
        .p0_q(p0_q), .p0_done(p0_done),
        .p1_addr(p_addr[1]), .p1_data(p_data[1]), .p1_we(p_we[1]), .p1_start(p_start[1]),
        .p1_q(p1_q), .p1_done(p1_done),
        .sdc_addr(sdc_addr), .sdc_data(sdc_data), .sdc_we(sdc_we), .sdc_start(sdc_start),
        .sdc_q(sdc_q), .sdc_done(sdc_done), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int done_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One transaction in flight at most: who owns it and what was captured.
    bit            m_busy;
    int            m_gnt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_we;
    logic [DW-1:0] m_hold[2];
    bit            m_arm[2];
    int            m_rr;

    task automatic model_reset();
        m_busy = 0; m_gnt = 0; m_addr = '0; m_data = '0; m_we = 0;
        m_hold[0] = '0; m_hold[1] = '0;
        m_arm[0] = 1; m_arm[1] = 1; m_rr = 1;
    endtask

    function automatic bit exp_done(input int n);
        return m_busy && (m_gnt == n) && (sdc_done === 1'b1) && (p_start[n] === 1'b1);
    endfunction

    task automatic model_update();
        bit new_arm[2];
        bit elig[2];
        int w;
        if (reset) begin
            model_reset();
            return;
        end
        for (int n = 0; n < 2; n++) begin
            if (exp_done(n)) m_hold[n] = sdc_q;
            new_arm[n] = m_arm[n];
            if (m_busy && sdc_done && m_gnt == n) new_arm[n] = 0;
            if (!p_start[n]) new_arm[n] = 1;
            elig[n] = p_start[n] && m_arm[n];
        end
        if (!m_busy) begin
            if (elig[0] || elig[1]) begin
                if (elig[0] && elig[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w = 1 - m_rr;
`else
                    w = 1;
`endif
                end else begin
                    w = elig[1] ? 1 : 0;
                end
                m_gnt  = w;
                m_addr = p_addr[w];
                m_data = p_data[w];
                m_we   = p_we[w];
                m_busy = 1;
            end
        end else if (sdc_done) begin
            m_busy = 0;
            m_rr   = m_gnt;
        end
        m_arm = new_arm;
    endtask

    task automatic check_all();
        chk("sdc_start", sdc_start, m_busy);
        chk("sdc_addr",  sdc_addr,  m_addr);
        chk("sdc_data",  sdc_data,  m_data);
        chk("sdc_we",    sdc_we,    m_we);
        chk("dbg_state", dbg_state, m_busy);
        chk("p0_done",   p0_done,   exp_done(0));
        chk("p1_done",   p1_done,   exp_done(1));
        chk("p0_q",      p0_q,      exp_done(0) ? sdc_q : m_hold[0]);
        chk("p1_q",      p1_q,      exp_done(1) ? sdc_q : m_hold[1]);
    endtask

    // ---------------- controller responder ----------------
    bit            ctl_auto = 1;
    bit            ctl_rand = 0;
    bit            spur_en  = 0;
    int            ctl_cnt  = 0;
    int            ctl_lat  = 3;
    logic [DW-1:0] ctl_qv   = 32'h0;

    // ---------------- driver tasks ----------------
    // settle: finish this cycle's inputs, then compare
    task automatic settle();
        if (ctl_auto) begin
            if (m_busy) begin
                ctl_cnt++;
                if (ctl_cnt >= ctl_lat) begin
                    sdc_done = 1'b1;
                    sdc_q    = ctl_qv;
                end else begin
                    sdc_done = 1'b0;
                    sdc_q    = $urandom;
                end
            end else begin
                ctl_cnt  = 0;
                sdc_done = spur_en && ($urandom_range(0, 9) == 0);
                sdc_q    = $urandom;
            end
        end
        #1;
        check_all();
    endtask

    // advance: step the model across the coming clock edge
    task automatic advance();
        if (ctl_auto && ctl_rand && m_busy && sdc_done) begin
            ctl_lat = $urandom_range(1, 6);
            ctl_qv  = $urandom;
        end
        model_update();
        @(negedge clk);
    endtask

    task automatic cyc();
        advance();
        settle();
    endtask

    task automatic wait_done(input int port, input int budget, output int cycles);
        cycles = -1;
        for (int i = 0; i < budget; i++) begin
            if ((port == 0 && p0_done === 1'b1) || (port == 1 && p1_done === 1'b1)) begin
                cycles = i;
                break;
            end
            cyc();
        end
        if (cycles < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: port %0d no done within %0d cycles", port, budget);
        end
    endtask

    // ---------------- test sequence ----------------
    int            cycles, c0, c1, first, second, hi;
    bit            pd0;
    logic [DW-1:0] prev;
    int            phase[2];
    int            hold_cnt[2];
    bit            prevd[2];

    initial begin
        reset = 1'b1;
        sdc_done = 1'b0;
        sdc_q = '0;
        for (int n = 0; n < 2; n++) begin
            p_addr[n] = '0; p_data[n] = '0; p_we[n] = 1'b0; p_start[n] = 1'b0;
        end
        model_reset();
        @(negedge clk);
        settle();
        chk("rst_sdc_start", sdc_start, 0);
        chk("rst_sdc_addr",  sdc_addr,  0);
        chk("rst_sdc_data",  sdc_data,  0);
        chk("rst_sdc_we",    sdc_we,    0);
        chk("rst_p0_q",      p0_q,      0);
        chk("rst_p1_q",      p1_q,      0);
        advance(); reset = 1'b0; settle();

        // 1: single p0 read, 5-cycle controller latency
        ctl_lat = 5; ctl_qv = 32'hDEADBEEF;
        advance(); p_start[0] = 1; p_addr[0] = 32'h000100; p_we[0] = 0; settle();
        chk("t1_idle_start", sdc_start, 0);
        advance(); settle();
        chk("t1_start_rise", sdc_start, 1);
        chk("t1_addr", sdc_addr, 32'h000100);
        chk("t1_we", sdc_we, 0);
        wait_done(0, 20, cycles);
        chk("t1_latency", cycles, 4);
        chk("t1_q", p0_q, 32'hDEADBEEF);
        chk("t1_p1_done", p1_done, 0);
        advance(); p_start[0] = 0; settle();
        chk("t1_done_pulse", p0_done, 0);
        chk("t1_q_held", p0_q, 32'hDEADBEEF);
        chk("t1_start_fall", sdc_start, 0);

        // 2: simultaneous requests, 4 rounds, from reset
        advance(); reset = 1; settle();
        advance(); reset = 0; settle();
        ctl_rand = 1;
        for (int r = 0; r < 4; r++) begin
            advance();
            p_start[0] = 1; p_addr[0] = 32'h1000 + r; p_we[0] = 0;
            p_start[1] = 1; p_addr[1] = 32'h2000 + r; p_we[1] = 0;
            settle();
            c0 = 0; c1 = 0;
            done_log.delete();
            for (int i = 0; i < 60; i++) begin
                if (p0_done === 1'b1) begin c0++; done_log.push_back(0); end
                if (p1_done === 1'b1) begin c1++; done_log.push_back(1); end
                if (c0 > 0 && c1 > 0) break;
                advance();
                if (c0 > 0) p_start[0] = 0;
                if (c1 > 0) p_start[1] = 0;
                settle();
            end
            first  = (done_log.size() > 0) ? done_log[0] : -1;
            second = (done_log.size() > 1) ? done_log[1] : -1;
            chk("t2_p0_dones", c0, 1);
            chk("t2_p1_dones", c1, 1);
            chk("t2_first", first, TIE_FIRST);
            chk("t2_second", second, 1 - TIE_FIRST);
            advance(); p_start[0] = 0; p_start[1] = 0; settle();
        end

        // 3: p1 write, inputs change while busy
        ctl_rand = 0; ctl_lat = 4; ctl_qv = 32'h0;
        advance();
        p_start[1] = 1; p_addr[1] = 32'h7FFFFC; p_data[1] = 32'h12345678; p_we[1] = 1;
        settle();
        advance(); p_addr[1] = 32'h0BAD0; p_data[1] = 32'hCAFEF00D; p_we[1] = 0; settle();
        cycles = -1;
        for (int i = 0; i < 20; i++) begin
            chk("t3_addr", sdc_addr, 32'h7FFFFC);
            chk("t3_data", sdc_data, 32'h12345678);
            chk("t3_we", sdc_we, 1);
            if (p1_done === 1'b1) begin cycles = i; break; end
            advance(); p_addr[1] = $urandom; p_data[1] = $urandom; settle();
        end
        chk("t3_done_at", cycles, 3);
        advance(); p_start[1] = 0; settle();

        // 4: p0 flushes its request mid-transaction
        ctl_lat = 6; ctl_qv = 32'h0F0F0F0F;
        prev = m_hold[0];
        advance(); p_start[0] = 1; p_addr[0] = 32'h200; p_we[0] = 0; settle();
        cyc(); cyc();
        advance(); p_start[0] = 0; settle();
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (sdc_start !== 1'b1) break;
            hi++;
            chk("t4_no_done", p0_done, 0);
            chk("t4_q_kept", p0_q, prev);
            cyc();
        end
        chk("t4_busy_tail", hi, 4);
        chk("t4_q_after", p0_q, prev);
        ctl_qv = 32'hA5A5A5A5;
        advance(); p_start[0] = 1; p_addr[0] = 32'h300; settle();
        wait_done(0, 20, cycles);
        chk("t4_next_lat", cycles, 6);
        chk("t4_next_q", p0_q, 32'hA5A5A5A5);
        advance(); p_start[0] = 0; settle();

        // 5: p1 keeps start high past its done; p0 served meanwhile
        ctl_lat = 3;
        advance(); p_start[1] = 1; p_addr[1] = 32'h5000; p_we[1] = 0; settle();
        advance(); p_start[0] = 1; p_addr[0] = 32'h6000; p_we[0] = 0; settle();
        wait_done(1, 20, cycles);
        for (int k = 1; k <= 6; k++) begin
            pd0 = exp_done(0);
            advance();
            if (k == 4) p_start[1] = 0;
            else if (k == 5) p_start[1] = 1;
            if (pd0) p_start[0] = 0;
            settle();
            if (k == 1) chk("t5_gap", sdc_start, 0);
            if (k == 2) begin
                chk("t5_p0_start", sdc_start, 1);
                chk("t5_p0_addr", sdc_addr, 32'h6000);
            end
            if (k == 4) chk("t5_p0_done", p0_done, 1);
            if (k == 6) begin
                chk("t5_p1_start", sdc_start, 1);
                chk("t5_p1_addr", sdc_addr, 32'h5000);
            end
        end
        wait_done(1, 20, cycles);
        advance(); p_start[1] = 0; settle();

        // 6: reset mid-transaction, stale done afterwards
        ctl_auto = 0; sdc_done = 0; sdc_q = 32'h99;
        advance(); p_start[0] = 1; p_addr[0] = 32'h700; settle();
        cyc(); cyc();
        advance(); reset = 1; settle();
        advance(); reset = 0; p_start[0] = 0; settle();
        chk("t6_start_drop", sdc_start, 0);
        advance();
        p_start[0] = 1; p_addr[0] = 32'h710;
        p_start[1] = 1; p_addr[1] = 32'h720;
        sdc_done = 1;
        settle();
        chk("t6_stale_p0", p0_done, 0);
        chk("t6_stale_p1", p1_done, 0);
        advance(); sdc_done = 0; settle();
        chk("t6_regrant", sdc_start, 1);
        chk("t6_tie_addr", sdc_addr, (TIE_FIRST == 0) ? 32'h710 : 32'h720);
        ctl_auto = 1; ctl_cnt = 1; ctl_lat = 3;
        wait_done(TIE_FIRST, 20, cycles);
        advance(); p_start[TIE_FIRST] = 0; settle();
        wait_done(1 - TIE_FIRST, 20, cycles);
        advance(); p_start[1 - TIE_FIRST] = 0; settle();

        // randomized traffic: flushes, lingering starts, spurious dones, resets
        ctl_rand = 1; spur_en = 1;
        phase[0] = 0; phase[1] = 0;
        hold_cnt[0] = 0; hold_cnt[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            prevd[0] = exp_done(0);
            prevd[1] = exp_done(1);
            advance();
            reset = ($urandom_range(0, 499) == 0);
            for (int n = 0; n < 2; n++) begin
                case (phase[n])
                    0: begin
                        p_start[n] = 0;
                        if ($urandom_range(0, 2) == 0) begin
                            p_start[n] = 1;
                            p_addr[n]  = $urandom;
                            p_data[n]  = $urandom;
                            p_we[n]    = $urandom_range(0, 1);
                            phase[n]   = 1;
                        end
                    end
                    1: begin
                        if (prevd[n]) begin
                            hold_cnt[n] = $urandom_range(0, 3);
                            if (hold_cnt[n] == 0) begin
                                p_start[n] = 0; phase[n] = 0;
                            end else begin
                                phase[n] = 2;
                            end
                        end else if ($urandom_range(0, 29) == 0) begin
                            p_start[n] = 0; phase[n] = 0;
                        end else if ($urandom_range(0, 5) == 0) begin
                            p_addr[n] = $urandom;
                            p_data[n] = $urandom;
                        end
                    end
                    default: begin
                        hold_cnt[n]--;
                        if (hold_cnt[n] <= 0) begin
                            p_start[n] = 0; phase[n] = 0;
                        end
                    end
                endcase
            end
            settle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
